// File: rtl/pgr_fwft_fifo.sv
// First-word-fall-through FIFO with valid/ready handshakes on both sides.
// Storage is a D-entry register array plus one registered output word, so
// the FIFO holds D+1 words in total. When the array is empty, an incoming
// word goes straight into the output register. The output word and its valid
// flag stay stable while the consumer applies backpressure. The FIFO also
// reports its fill level and two programmable almost-flags, and supports a
// synchronous flush.
module pgr_fwft_fifo #(
  parameter int W        = 8,
  parameter int D        = 16,
  parameter int AF_LEVEL = D - 2,
  parameter int AE_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 data_in_valid,
  input  logic [W-1:0]         data_in,
  output logic                 data_in_ready,
  output logic                 data_out_valid,
  output logic [W-1:0]         data_out,
  input  logic                 data_out_ready,
  output logic [$clog2(D):0]   level,
  output logic                 almost_full,
  output logic                 almost_empty
);

  localparam int AW = $clog2(D);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Storage and registered state
  logic [W-1:0] mem_q [D];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [W-1:0] dout_q, dout_d;
  logic         dout_valid_q, dout_valid_d;
  logic [AW:0]  level_q, level_d;

  // Handshake and array status
  logic [AW:0]  arr_cnt;
  logic         arr_empty;
  logic         arr_full;
  logic         push;
  logic         pop;
  logic         out_load;
  logic         bypass;
  logic         mem_we;

  // Wrap bit on each pointer lets a plain subtraction tell full apart from empty.
  assign arr_cnt   = wr_ptr_q - rd_ptr_q;
  assign arr_empty = (wr_ptr_q == rd_ptr_q);
  assign arr_full  = (int'(arr_cnt) == D);

  assign data_in_ready = rst_n & ~flush & ~arr_full;
  assign push          = data_in_valid & data_in_ready;
  assign pop           = dout_valid_q & data_out_ready;
  // The output register may take a new word only when it is empty or being consumed.
  assign out_load      = ~dout_valid_q | data_out_ready;
  assign bypass        = out_load & arr_empty & push;

  // Next-state logic: output register refill, pointer moves, level tracking, flush.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    level_d      = level_q;
    mem_we       = 1'b0;

    if (out_load) begin
      if (!arr_empty) begin
        dout_d       = mem_q[rd_ptr_q[AW-1:0]];
        dout_valid_d = 1'b1;
        rd_ptr_d     = rd_ptr_q + PTR_ONE;
      end else if (push) begin
        dout_d       = data_in;
        dout_valid_d = 1'b1;
      end else begin
        dout_valid_d = 1'b0;
      end
    end

    if (push && !bypass) begin
      mem_we   = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    if (push && !pop) begin
      level_d = level_q + PTR_ONE;
    end else if (pop && !push) begin
      level_d = level_q - PTR_ONE;
    end

    // Flush empties the FIFO but keeps the last output word on data_out.
    if (flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      dout_d       = dout_q;
      dout_valid_d = 1'b0;
      level_d      = '0;
      mem_we       = 1'b0;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      level_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      level_q      <= level_d;
    end
  end

  // Array write port.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; the pointers alone decide which entries are live.
    if (mem_we) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_in;
    end
  end

  assign data_out_valid = dout_valid_q;
  assign data_out       = dout_q;
  assign level          = level_q;
  assign almost_full    = (int'(level_q) >= AF_LEVEL);
  assign almost_empty   = (int'(level_q) <= AE_LEVEL);

endmodule

// File: tb/tb_pgr_fwft_fifo.sv
// Directed and randomised-stream bench for pgr_fwft_fifo at W=8, D=16.
// Inputs are driven 1 ns after each rising edge and outputs are sampled
// there too, well away from the next edge.
module tb_pgr_fwft_fifo;

  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         data_in_valid;
  logic [W-1:0] data_in;
  logic         data_in_ready;
  logic         data_out_valid;
  logic [W-1:0] data_out;
  logic         data_out_ready;
  logic [4:0]   level;
  logic         almost_full;
  logic         almost_empty;

  int checks = 0;
  int errors = 0;

  pgr_fwft_fifo #(.W(W), .D(D)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .data_in_valid  (data_in_valid),
    .data_in        (data_in),
    .data_in_ready  (data_in_ready),
    .data_out_valid (data_out_valid),
    .data_out       (data_out),
    .data_out_ready (data_out_ready),
    .level          (level),
    .almost_full    (almost_full),
    .almost_empty   (almost_empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_b;
  int         sent;
  int         rcvd;
  int         cyc;
  int         max_lvl;

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    data_in_valid  = 1'b1;
    data_in        = 8'h55;
    data_out_ready = 1'b0;

    // 1: reset with a producer already asserting valid
    tick();
    tick();
    check("rst_ready", data_in_ready, 0);
    check("rst_valid", data_out_valid, 0);
    check("rst_level", level, 0);
    check("rst_ae", almost_empty, 1);
    check("rst_af", almost_full, 0);
    check("rst_dout", data_out, 0);
    rst_n         = 1'b1;
    data_in_valid = 1'b0;
    tick();

    // 2: bypass into empty FIFO, then hold under backpressure
    data_in_valid = 1'b1;
    data_in       = 8'hA5;
    #1;
    check("byp_ready", data_in_ready, 1);
    tick();
    data_in_valid = 1'b0;
    check("byp_valid", data_out_valid, 1);
    check("byp_data", data_out, 8'hA5);
    check("byp_level", level, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", data_out_valid, 1);
      check("hold_data", data_out, 8'hA5);
    end
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    check("byp_drain_valid", data_out_valid, 0);
    check("byp_drain_level", level, 0);

    // 3: fill to D+1 words, reject one more, drain in order
    for (int i = 0; i < 17; i++) begin
      data_in_valid = 1'b1;
      data_in       = 8'(i);
      #1;
      check("fill_ready", data_in_ready, 1);
      check("fill_level", level, i);
      check("fill_af", almost_full, (i >= 14) ? 1 : 0);
      tick();
    end
    data_in = 8'h11;
    #1;
    check("full_ready", data_in_ready, 0);
    check("full_level", level, 17);
    check("full_af", almost_full, 1);
    tick();
    data_in_valid = 1'b0;
    check("reject_level", level, 17);
    data_out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      check("drain_valid", data_out_valid, 1);
      check("drain_data", data_out, i);
      tick();
    end
    data_out_ready = 1'b0;
    check("drain_empty_valid", data_out_valid, 0);
    check("drain_empty_level", level, 0);
    check("drain_ae", almost_empty, 1);

    // 4: random streaming, 1000 words against a queue model
    sent    = 0;
    rcvd    = 0;
    cyc     = 0;
    max_lvl = 0;
    while (rcvd < 1000 && cyc < 20000) begin
      data_in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      data_in        = 8'($urandom);
      data_out_ready = ($urandom_range(0, 1) == 1);
      #1;
      check("s_level", level, q.size());
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (data_out_valid && data_out_ready) begin
        if (q.size() == 0) begin
          check("s_spurious", 1, 0);
        end else begin
          exp_b = q.pop_front();
          check("s_data", data_out, exp_b);
        end
        rcvd++;
      end
      if (data_in_valid && data_in_ready) begin
        q.push_back(data_in);
        sent++;
      end
      tick();
      cyc++;
    end
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    check("s_sent", sent, 1000);
    check("s_rcvd", rcvd, 1000);
    check("s_max_level", (max_lvl <= 17) ? 1 : 0, 1);
    check("s_end_level", level, 0);
    q.delete();

    // 5: simultaneous push and pop with only the output register occupied
    data_in_valid = 1'b1;
    data_in       = 8'h11;
    tick();
    check("sim_pre_level", level, 1);
    data_in        = 8'h22;
    data_out_ready = 1'b1;
    tick();
    data_in_valid  = 1'b0;
    data_out_ready = 1'b0;
    check("sim_level", level, 1);
    check("sim_valid", data_out_valid, 1);
    check("sim_data", data_out, 8'h22);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    check("sim_drain_level", level, 0);

    // 6: flush with a push attempt, then verify no stale data
    for (int i = 0; i < 9; i++) begin
      data_in_valid = 1'b1;
      data_in       = 8'(8'h40 + i);
      tick();
    end
    check("fl_pre_level", level, 9);
    flush         = 1'b1;
    data_in       = 8'h99;
    #1;
    check("fl_ready", data_in_ready, 0);
    tick();
    flush         = 1'b0;
    data_in_valid = 1'b0;
    check("fl_level", level, 0);
    check("fl_valid", data_out_valid, 0);
    check("fl_ae", almost_empty, 1);
    check("fl_dout_held", data_out, 8'h40);
    data_in_valid = 1'b1;
    data_in       = 8'h3C;
    tick();
    data_in_valid = 1'b0;
    check("fl_post_valid", data_out_valid, 1);
    check("fl_post_data", data_out, 8'h3C);
    check("fl_post_level", level, 1);
    data_out_ready = 1'b1;
    tick();
    data_out_ready = 1'b0;
    check("fl_post_empty", data_out_valid, 0);
    check("fl_post_level0", level, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
